// File: rtl/mask_centroid_calc.sv
// mask_centroid_calc
//   Consumes the 1-bit mask stream from the 3x3 red-pixel filter, tracks
//   pixel coordinates, accumulates per-frame set-pixel count and coordinate
//   sums, and at frame end computes the centroid with a serial restoring
//   divider (one quotient bit per cycle). The result is held on a
//   valid/ready port until accepted.
//
//   Optional build macro: CENTROID_BBOX_EN adds a per-frame bounding box of
//   the set pixels (o_xmin/o_xmax/o_ymin/o_ymax), snapshotted and held with
//   the centroid.
//
// Ports:
//   i_clk, i_rstn          clock, synchronous active-low reset
//   i_tdata/tuser/tlast    mask bit, start of frame, end of line
//   i_tvalid, o_tready     input handshake (o_tready is tied high)
//   o_cx, o_cy             centroid column / row
//   o_count, o_found       set-pixel count, count >= MIN_COUNT
//   o_valid, i_ready       result handshake
//   o_drop                 one-cycle pulse when a frame result is discarded
module mask_centroid_calc #(
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 10,
    parameter int FRAME_HEIGHT = 480,
    parameter int MIN_COUNT    = 16,
    localparam int CNT_W       = X_WIDTH + Y_WIDTH,
    localparam int SX_W        = CNT_W + X_WIDTH,
    localparam int SY_W        = CNT_W + Y_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_tdata,
    input  logic               i_tuser,
    input  logic               i_tlast,
    input  logic               i_tvalid,
    output logic               o_tready,
    output logic [X_WIDTH-1:0] o_cx,
    output logic [Y_WIDTH-1:0] o_cy,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_found,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_drop
`ifdef CENTROID_BBOX_EN
    ,
    output logic [X_WIDTH-1:0] o_xmin,
    output logic [X_WIDTH-1:0] o_xmax,
    output logic [Y_WIDTH-1:0] o_ymin,
    output logic [Y_WIDTH-1:0] o_ymax
`endif
);

    // Both divisions share one dividend register, sized for the wider one.
    localparam int NUM_W = (SX_W > SY_W) ? SX_W : SY_W;
    localparam int BIT_W = $clog2(NUM_W + 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST  = Y_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_COUNT);
    localparam logic [BIT_W-1:0]   X_LAST_BIT = BIT_W'(SX_W - 1);
    localparam logic [BIT_W-1:0]   Y_LAST_BIT = BIT_W'(SY_W - 1);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, HOLD} state_t;
    state_t state, state_next;

    logic [X_WIDTH-1:0] x, bx;
    logic [Y_WIDTH-1:0] y, by;
    logic [CNT_W-1:0]   cnt, cnt_add;
    logic [SX_W-1:0]    sx, sx_add;
    logic [SY_W-1:0]    sy, sy_add;
    logic               frame_end;

    logic [NUM_W-1:0]   num, num_next;
    logic [CNT_W-1:0]   rem, rem_next, divisor;
    logic [CNT_W:0]     rem_shift;
    logic               sub_ok;
    logic [SY_W-1:0]    snap_sy;
    logic [BIT_W-1:0]   bit_idx;

    assign o_tready = 1'b1;

    // Beat contribution: a SOF beat is (0,0) and starts from empty sums.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bx      = i_tuser ? '0 : x;
        by      = i_tuser ? '0 : y;
        cnt_add = i_tuser ? '0 : cnt;
        sx_add  = i_tuser ? '0 : sx;
        sy_add  = i_tuser ? '0 : sy;
        if (i_tdata) begin
            cnt_add = cnt_add + CNT_W'(1);
            sx_add  = sx_add + SX_W'(bx);
            sy_add  = sy_add + SY_W'(by);
        end
    end

    assign frame_end = i_tvalid && i_tlast && (by == Y_LAST);

`ifdef CENTROID_BBOX_EN
    logic [X_WIDTH-1:0] xmin, xmax, xmin_add, xmax_add, snap_xmin, snap_xmax;
    logic [Y_WIDTH-1:0] ymin, ymax, ymin_add, ymax_add, snap_ymin, snap_ymax;

    always_comb begin
        xmin_add = i_tuser ? '1 : xmin;
        xmax_add = i_tuser ? '0 : xmax;
        ymin_add = i_tuser ? '1 : ymin;
        ymax_add = i_tuser ? '0 : ymax;
        if (i_tdata) begin
            if (bx < xmin_add) xmin_add = bx;
            if (bx > xmax_add) xmax_add = bx;
            if (by < ymin_add) ymin_add = by;
            if (by > ymax_add) ymax_add = by;
        end
    end
`endif

    // Coordinate tracking and per-frame accumulation.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            x   <= '0;
            y   <= '0;
            cnt <= '0;
            sx  <= '0;
            sy  <= '0;
`ifdef CENTROID_BBOX_EN
            xmin <= '0;
            xmax <= '0;
            ymin <= '0;
            ymax <= '0;
`endif
        end else if (i_tvalid) begin
            if (i_tlast) begin
                x <= '0;
                y <= (by == Y_LAST) ? '0 : by + Y_WIDTH'(1);
            end else begin
                x <= bx + X_WIDTH'(1);
                y <= by;
            end
            if (frame_end) begin
                cnt <= '0;
                sx  <= '0;
                sy  <= '0;
`ifdef CENTROID_BBOX_EN
                xmin <= '1;
                xmax <= '0;
                ymin <= '1;
                ymax <= '0;
`endif
            end else begin
                cnt <= cnt_add;
                sx  <= sx_add;
                sy  <= sy_add;
`ifdef CENTROID_BBOX_EN
                xmin <= xmin_add;
                xmax <= xmax_add;
                ymin <= ymin_add;
                ymax <= ymax_add;
`endif
            end
        end
    end

    // One restoring-division step: bring in the next dividend bit, subtract
    // the divisor when it fits, shift the quotient bit into the LSB.
    always_comb begin
        rem_shift = {rem, num[NUM_W-1]};
        sub_ok    = (rem_shift >= {1'b0, divisor});
        rem_next  = sub_ok ? CNT_W'(rem_shift - {1'b0, divisor}) : rem_shift[CNT_W-1:0];
        num_next  = {num[NUM_W-2:0], sub_ok};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (frame_end) state_next = (cnt_add < MIN_CNT) ? HOLD : DIV_X;
            DIV_X: if (bit_idx == X_LAST_BIT) state_next = DIV_Y;
            DIV_Y: if (bit_idx == Y_LAST_BIT) state_next = HOLD;
            HOLD:  if (o_valid && i_ready) state_next = IDLE;
        endcase
    end

    // Divider datapath and result registers. o_valid rises one cycle after
    // HOLD is entered, so the low-count bypass and the divided path share
    // the same output timing relative to HOLD entry.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            num     <= '0;
            rem     <= '0;
            divisor <= '0;
            snap_sy <= '0;
            bit_idx <= '0;
            o_cx    <= '0;
            o_cy    <= '0;
            o_count <= '0;
            o_found <= 1'b0;
            o_valid <= 1'b0;
            o_drop  <= 1'b0;
`ifdef CENTROID_BBOX_EN
            snap_xmin <= '0;
            snap_xmax <= '0;
            snap_ymin <= '0;
            snap_ymax <= '0;
            o_xmin    <= '0;
            o_xmax    <= '0;
            o_ymin    <= '0;
            o_ymax    <= '0;
`endif
        end else begin
            o_drop <= frame_end && (state != IDLE);
            unique case (state)
                IDLE: if (frame_end) begin
                    divisor <= cnt_add;
                    snap_sy <= sy_add;
                    // Left-align so the dividend MSB is consumed first.
                    num     <= NUM_W'(sx_add) << (NUM_W - SX_W);
                    rem     <= '0;
                    bit_idx <= '0;
`ifdef CENTROID_BBOX_EN
                    snap_xmin <= xmin_add;
                    snap_xmax <= xmax_add;
                    snap_ymin <= ymin_add;
                    snap_ymax <= ymax_add;
`endif
                    if (cnt_add < MIN_CNT) begin
                        o_cx    <= '0;
                        o_cy    <= '0;
                        o_count <= cnt_add;
                        o_found <= 1'b0;
`ifdef CENTROID_BBOX_EN
                        o_xmin <= '0;
                        o_xmax <= '0;
                        o_ymin <= '0;
                        o_ymax <= '0;
`endif
                    end
                end
                DIV_X: begin
                    num     <= num_next;
                    rem     <= rem_next;
                    bit_idx <= bit_idx + BIT_W'(1);
                    if (bit_idx == X_LAST_BIT) begin
                        o_cx    <= num_next[X_WIDTH-1:0];
                        num     <= NUM_W'(snap_sy) << (NUM_W - SY_W);
                        rem     <= '0;
                        bit_idx <= '0;
                    end
                end
                DIV_Y: begin
                    num     <= num_next;
                    rem     <= rem_next;
                    bit_idx <= bit_idx + BIT_W'(1);
                    if (bit_idx == Y_LAST_BIT) begin
                        o_cy    <= num_next[Y_WIDTH-1:0];
                        o_count <= divisor;
                        o_found <= 1'b1;
`ifdef CENTROID_BBOX_EN
                        o_xmin <= snap_xmin;
                        o_xmax <= snap_xmax;
                        o_ymin <= snap_ymin;
                        o_ymax <= snap_ymax;
`endif
                    end
                end
                HOLD: begin
                    if (!o_valid)     o_valid <= 1'b1;
                    else if (i_ready) o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_centroid_calc.sv
// Directed bench for mask_centroid_calc on a 4x4 frame. Two instances share
// the input stream: dut (MIN_COUNT=1) and dut_lo (MIN_COUNT=16).
module tb_mask_centroid_calc;

    localparam int XW  = 10;
    localparam int YW  = 10;
    localparam int CW  = XW + YW;
    localparam int LAT = 1 + (CW + XW) + (CW + YW);

    logic          clk, rstn;
    logic          tdata, tuser, tlast, tvalid;
    logic          rdy, rdy_lo;
    logic          tready, tready_lo;
    logic [XW-1:0] cx, cx_lo;
    logic [YW-1:0] cy, cy_lo;
    logic [CW-1:0] count, count_lo;
    logic          found, found_lo, valid, valid_lo, drop, drop_lo;
`ifdef CENTROID_BBOX_EN
    logic [XW-1:0] xmin, xmax, xmin_lo, xmax_lo;
    logic [YW-1:0] ymin, ymax, ymin_lo, ymax_lo;
`endif

    int checks   = 0;
    int failures = 0;
    int drop_cnt = 0;

    mask_centroid_calc #(.X_WIDTH(XW), .Y_WIDTH(YW), .FRAME_HEIGHT(4), .MIN_COUNT(1)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_tdata(tdata), .i_tuser(tuser), .i_tlast(tlast),
        .i_tvalid(tvalid), .o_tready(tready), .o_cx(cx), .o_cy(cy), .o_count(count),
        .o_found(found), .o_valid(valid), .i_ready(rdy), .o_drop(drop)
`ifdef CENTROID_BBOX_EN
        , .o_xmin(xmin), .o_xmax(xmax), .o_ymin(ymin), .o_ymax(ymax)
`endif
    );

    mask_centroid_calc #(.X_WIDTH(XW), .Y_WIDTH(YW), .FRAME_HEIGHT(4), .MIN_COUNT(16)) dut_lo (
        .i_clk(clk), .i_rstn(rstn), .i_tdata(tdata), .i_tuser(tuser), .i_tlast(tlast),
        .i_tvalid(tvalid), .o_tready(tready_lo), .o_cx(cx_lo), .o_cy(cy_lo), .o_count(count_lo),
        .o_found(found_lo), .o_valid(valid_lo), .i_ready(rdy_lo), .o_drop(drop_lo)
`ifdef CENTROID_BBOX_EN
        , .o_xmin(xmin_lo), .o_xmax(xmax_lo), .o_ymin(ymin_lo), .o_ymax(ymax_lo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (drop === 1'b1) drop_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends one 4x4 frame; mask bit index is y*4+x. Returns at the negedge
    // just after the edge that accepted the final (frame-end) beat.
    task automatic send_frame(input logic [15:0] m, input int rows);
        for (int yy = 0; yy < rows; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                tvalid = 1'b1;
                tdata  = m[yy*4 + xx];
                tuser  = (xx == 0 && yy == 0);
                tlast  = (xx == 3);
                cycle();
            end
        end
        tvalid = 1'b0;
        tdata  = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 200) begin
            cycle();
            n++;
        end
    endtask

    task automatic handshake(input string tag);
        rdy = 1'b1;
        cycle();
        rdy = 1'b0;
        check(tag, valid, 1'b0);
    endtask

    int n;
    int drops_before;
    bit seen_valid;

    initial begin
        rstn = 1'b0; tdata = 1'b0; tuser = 1'b0; tlast = 1'b0; tvalid = 1'b0;
        rdy = 1'b0; rdy_lo = 1'b0;
        repeat (3) cycle();
        check("rst_valid", valid, 1'b0);
        check("rst_tready", tready, 1'b1);
        check("rst_count", count, 0);
        check("rst_cx", cx, 0);
        check("rst_drop", drop, 1'b0);
        rstn = 1'b1;
        cycle();

        // Frame A: (0,0),(1,1),(2,2). Low-count instance bypasses division.
        send_frame(16'h0421, 4);
        check("lo_valid_e0", valid_lo, 1'b0);
        cycle();
        check("lo_valid_e1", valid_lo, 1'b1);
        check("lo_found", found_lo, 1'b0);
        check("lo_cx", cx_lo, 0);
        check("lo_cy", cy_lo, 0);
        check("lo_count", count_lo, 3);
        rdy_lo = 1'b1;
        wait_valid(n);
        check("a_latency", n, LAT - 1);
        check("a_cx", cx, 1);
        check("a_cy", cy, 1);
        check("a_count", count, 3);
        check("a_found", found, 1'b1);
        handshake("a_ack");

        // Frame B: single pixel (2,1); exact latency.
        send_frame(16'h0040, 4);
        wait_valid(n);
        check("b_latency", n, LAT);
        check("b_cx", cx, 2);
        check("b_cy", cy, 1);
        check("b_count", count, 1);
        check("b_found", found, 1'b1);
        handshake("b_ack");

        // Reset in DIV_X aborts the division.
        send_frame(16'h0040, 4);
        repeat (5) cycle();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (valid === 1'b1) seen_valid = 1'b1;
        end
        check("rst_div_no_valid", seen_valid, 1'b0);
        check("rst_div_count", count, 0);

        // Frame C: (1,0),(3,0),(0,3),(3,3): sx=7 sy=6 cnt=4.
        send_frame(16'h900A, 4);
        wait_valid(n);
        check("c_latency", n, LAT);
        check("c_cx", cx, 1);
        check("c_cy", cy, 1);
        check("c_count", count, 4);
        check("pre_drop_cnt", drop_cnt, 0);

        // Frame D while C is held: dropped, C result unchanged.
        drops_before = drop_cnt;
        send_frame(16'h0208, 4);
        repeat (4) cycle();
        check("drop_pulses", drop_cnt - drops_before, 1);
        check("hold_valid", valid, 1'b1);
        check("hold_cx", cx, 1);
        check("hold_cy", cy, 1);
        check("hold_count", count, 4);
        handshake("c_ack");

        // Frame D after release: (1,2),(3,0).
        send_frame(16'h0208, 4);
        wait_valid(n);
        check("d_latency", n, LAT);
        check("d_cx", cx, 2);
        check("d_cy", cy, 1);
        check("d_count", count, 2);
`ifdef CENTROID_BBOX_EN
        check("d_xmin", xmin, 1);
        check("d_xmax", xmax, 3);
        check("d_ymin", ymin, 0);
        check("d_ymax", ymax, 2);
`endif
        handshake("d_ack");

        // Mid-frame SOF: partial frame (two full rows) then a fresh frame B.
        drops_before = drop_cnt;
        send_frame(16'h00FF, 2);
        send_frame(16'h0040, 4);
        wait_valid(n);
        check("resync_latency", n, LAT);
        check("resync_cx", cx, 2);
        check("resync_cy", cy, 1);
        check("resync_count", count, 1);
        check("resync_no_drop", drop_cnt - drops_before, 0);
        handshake("resync_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mask_centroid_calc.md
Name: mask_centroid_calc

Overview:
Sits directly downstream of the 3x3 red-pixel mask filter and consumes its 1-bit AXI-Stream mask (tdata = mask, tuser = SOF, tlast = EOL).
- Tracks pixel coordinates and accumulates per-frame count, sum-x and sum-y of set mask pixels.
- At frame end, computes the centroid with a serial restoring divider.
- Presents the result on a held valid/ready output port to the object-tracking/overlay logic.

Parameters:
X_WIDTH, 10, column coordinate width; the frame is at most 2^X_WIDTH pixels wide.
Y_WIDTH, 10, row coordinate width.
FRAME_HEIGHT, 480, number of lines per frame; the frame ends on the EOL of row FRAME_HEIGHT-1.
MIN_COUNT, 16, minimum set-pixel count for a valid detection.
Derived widths: CNT_W = X_WIDTH+Y_WIDTH, SX_W = CNT_W+X_WIDTH, SY_W = CNT_W+Y_WIDTH.

Ports:
i_clk  in  1  clock
i_rstn  in  1  synchronous active-low reset
i_tdata  in  1  mask bit of current pixel
i_tuser  in  1  start of frame (pixel 0,0)
i_tlast  in  1  end of line
i_tvalid  in  1  input beat valid
o_tready  out  1  input ready; constant 1, the block never stalls
o_cx  out  X_WIDTH  centroid column
o_cy  out  Y_WIDTH  centroid row
o_count  out  CNT_W  set-pixel count of the frame
o_found  out  1  count >= MIN_COUNT
o_valid  out  1  result valid
i_ready  in  1  result accepted
o_drop  out  1  one-cycle pulse: a frame result was discarded

Behaviour:
Reset:
- Reset is i_rstn, synchronous, active-low; clock is i_clk.
- Reset sets x=0, y=0, all accumulators to 0 and state to IDLE.
- All outputs reset to 0 except o_tready=1.
- Reset mid-division aborts the division; no result is emitted.

Accumulate (every beat with i_tvalid=1):
- Coordinates: if i_tuser=1, the beat is taken as (0,0) and accumulators are cleared before adding the beat. Otherwise the current x,y are used.
- If i_tdata=1: cnt += 1, sx += x, sy += y.
- After the beat: if i_tlast=1, x <= 0 and y <= y+1, wrapping to 0 when y == FRAME_HEIGHT-1. Otherwise x <= x+1.
- Counters wrap modulo width; overflow is not checked.

Frame end:
- A frame ends on an accepted beat with i_tlast=1 and y == FRAME_HEIGHT-1.
- In IDLE: cnt, sx and sy, including that beat's contribution, are snapshotted into divider registers, and the accumulators are cleared.
- In any other state: the frame is discarded, o_drop pulses for 1 cycle, and the accumulators are still cleared.

FSM (IDLE -> DIV_X -> DIV_Y -> HOLD -> IDLE):
- IDLE: on frame end, if snapshot cnt < MIN_COUNT, go directly to HOLD with cx=cy=0 and found=0; o_valid rises on the next cycle. Otherwise go to DIV_X.
- DIV_X: restoring shift-subtract, one quotient bit per cycle, SX_W cycles; computes floor(sx/cnt), truncated to X_WIDTH.
- DIV_Y: same for sy, SY_W cycles.
- HOLD: o_valid=1. o_cx, o_cy, o_count and o_found are stable until i_ready=1; then o_valid <= 0 and return to IDLE.
- Latency: o_valid rises exactly 1+SX_W+SY_W cycles after the edge accepting the frame-end beat.
- A frame end arriving on the same cycle as the HOLD handshake is dropped, because the state is not IDLE at that edge.
- A mid-frame i_tuser resynchronises the counters and discards the partial frame without pulsing o_drop.

Optional Feature:
Macro: CENTROID_BBOX_EN.
- Defined: adds outputs o_xmin and o_xmax (X_WIDTH each) and o_ymin and o_ymax (Y_WIDTH each).
- Box tracking: per frame, min/max of set-pixel coordinates, initialised to min=all-ones and max=0 at frame start. The values are snapshotted with the sums and held with o_valid. If found=0, all four outputs are 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single pixel, FRAME_HEIGHT=4, width 4, MIN_COUNT=1, mask set only at (2,1) -> o_cx=2, o_cy=1, o_count=1, o_found=1; o_valid exactly 1+SX_W+SY_W cycles after the row-3 EOL.
- Pixels (1,0), (3,0), (0,3), (3,3) with MIN_COUNT=1 -> sum-x=7, sum-y=6, count=4; o_cx=1 and o_cy=1, floor-truncated.
- Frame with 3 set pixels and MIN_COUNT=16 -> o_valid one cycle after frame end; o_found=0, o_cx=o_cy=0, o_count=3.
- Hold i_ready=0 through the next frame end -> o_drop pulses once; the held result is unchanged. Release i_ready -> the next frame's result is emitted normally.
- Reset pulse in DIV_X -> o_valid stays 0; the following full frame produces the correct centroid.
- CENTROID_BBOX_EN defined, pixels (1,2) and (3,0) -> o_xmin=1, o_xmax=3, o_ymin=0, o_ymax=2.
